// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared FSM state encoding and vector count for the gate BIST sequencer
package gate_bist_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;
  localparam int NUM_VECTORS = 4;
endpackage

// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: run control (start/abort) and results (busy/done/pass/fail_cnt/fail_vec); master = harness, slave = gate_bist_ctrl
interface gate_bist_ctrl_if #(parameter int FCW = 8);
  logic start, abort, busy, done, pass;
  logic [FCW-1:0] fail_cnt;
  logic [1:0] fail_vec;
  modport master(output start, abort, input busy, done, pass, fail_cnt, fail_vec);
  modport slave(input start, abort, output busy, done, pass, fail_cnt, fail_vec);
endinterface

// File: rtl/gate_bist_ctrl_settle_timer.sv
// settle_timer: loadable down-counter with zero flag; ports clk, rst, load (reload LOAD), en (count down), zero
module settle_timer #(
  parameter int W = 1,
  parameter logic [W-1:0] LOAD = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= LOAD;
    else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: 2-input gate self-test sequencer; ports clk, rst, gate_y (in), gate_a/gate_b (out), bus (slave: start/abort in, busy/done/pass/fail_cnt/fail_vec out)
module gate_bist_ctrl import gate_bist_pkg::*; #(
  parameter logic [3:0] TRUTH = 4'b0111,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS = 1,
  parameter int FCW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic gate_y,
  output logic gate_a,
  output logic gate_b,
  gate_bist_ctrl_if.slave bus
);
  localparam int LW = $clog2(LOOPS + 1);
  localparam int TW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state;
  logic [1:0] vec;
  logic [LW-1:0] loop;
  logic zero, go, miss, last, tload;
  logic [FCW-1:0] cnt_nx;
  assign go = bus.start && !bus.abort;
  assign miss = gate_y != TRUTH[vec];
  assign last = vec == 2'(NUM_VECTORS - 1) && loop == LW'(LOOPS - 1);
  assign cnt_nx = miss && bus.fail_cnt != '1 ? bus.fail_cnt + 1'b1 : bus.fail_cnt;
  // timer is reloaded whenever a new vector begins its settle window
  assign tload = (state == IDLE && go) || (state == SAMPLE && !bus.abort && !last);
  settle_timer #(.W(TW), .LOAD(TW'(SETTLE_CYCLES - 1))) u_timer (
    .clk(clk), .rst(rst), .load(tload), .en(state == SETTLE), .zero(zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      loop <= '0;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.fail_cnt <= '0;
      bus.fail_vec <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.pass <= 1'b0;
        gate_a <= 1'b0;
        gate_b <= 1'b0;
      end else case (state)
        IDLE: if (go) begin
          state <= SETTLE;
          vec <= '0;
          loop <= '0;
          gate_a <= 1'b0;
          gate_b <= 1'b0;
          bus.fail_cnt <= '0;
          bus.pass <= 1'b0;
          bus.busy <= 1'b1;
        end
        SETTLE: if (zero) state <= SAMPLE;
        SAMPLE: begin
          bus.fail_cnt <= cnt_nx;
          if (miss && bus.fail_cnt == '0) bus.fail_vec <= vec;
          if (last) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.pass <= cnt_nx == '0;
            bus.busy <= 1'b0;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else begin
            state <= SETTLE;
            vec <= vec + 2'd1;
            if (vec == 2'(NUM_VECTORS - 1)) loop <= loop + 1'b1;
            {gate_a, gate_b} <= vec + 2'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: table, random and corner-case checks of gate_bist_ctrl against a behavioural model
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;
  localparam int S0 = 2, L0 = 1, LAT0 = 1 + L0 * NUM_VECTORS * (S0 + 1);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] gfun = 4'b0111, truth0 = 4'b0111;
  logic [3:0] ga, gb, gy, dn;
  int n_vec = 0, n_fail = 0;
  gate_bist_ctrl_if #(.FCW(8)) b0 ();
  gate_bist_ctrl_if #(.FCW(8)) b1 ();
  gate_bist_ctrl_if #(.FCW(8)) b2 ();
  gate_bist_ctrl_if #(.FCW(2)) b3 ();
  assign {b0.start, b1.start, b2.start, b3.start} = {4{start}};
  assign {b0.abort, b1.abort, b2.abort, b3.abort} = {4{abort}};
  assign dn = {b3.done, b2.done, b1.done, b0.done};
  assign gy[0] = gfun[{ga[0], gb[0]}];
  assign gy[1] = ga[1] & gb[1];
  assign gy[3:2] = 2'b11;
  gate_bist_ctrl u0 (.clk(clk), .rst(rst), .gate_y(gy[0]), .gate_a(ga[0]), .gate_b(gb[0]), .bus(b0));
  gate_bist_ctrl #(.TRUTH(4'b1000)) u1 (.clk(clk), .rst(rst), .gate_y(gy[1]), .gate_a(ga[1]), .gate_b(gb[1]), .bus(b1));
  gate_bist_ctrl #(.LOOPS(3), .SETTLE_CYCLES(1)) u2 (.clk(clk), .rst(rst), .gate_y(gy[2]), .gate_a(ga[2]), .gate_b(gb[2]), .bus(b2));
  gate_bist_ctrl #(.FCW(2), .LOOPS(4)) u3 (.clk(clk), .rst(rst), .gate_y(gy[3]), .gate_a(ga[3]), .gate_b(gb[3]), .bus(b3));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] g;
    int ab, rs, cnt, vec, pass, de;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] g, input int ab, output int c, output int v, output int p);
    c = 0;
    v = 0;
    for (int j = 0; j < L0 * NUM_VECTORS; j++)
      if ((ab == 0 || (j + 1) * (S0 + 1) < ab) && g[j % NUM_VECTORS] != truth0[j % NUM_VECTORS]) begin
        if (c == 0) v = j % NUM_VECTORS;
        c = c < 255 ? c + 1 : c;
      end
    p = (ab == 0 && c == 0) ? 1 : 0;
  endfunction
  task automatic run0(input logic [3:0] g, input int ab, input int rs, input int ec, input int ev, input int ep, input int ed);
    int de, nd;
    de = 0;
    nd = 0;
    gfun = g;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start", {b0.busy, ga[0], gb[0]}, 3'b100);
    for (int k = 1; k <= LAT0 + 6; k++) begin
      abort = k == ab;
      start = k == rs;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (b0.done) begin
        nd++;
        if (de == 0) de = k + 1;
      end
      if (ab != 0 && k >= ab) chk("abort_idle", {b0.busy, ga[0], gb[0]}, 0);
      else if (k < LAT0 - 1) chk("trace", {b0.busy, ga[0], gb[0]}, {1'b1, 2'((k / (S0 + 1)) % NUM_VECTORS)});
      else chk("finish", {b0.busy, ga[0], gb[0]}, 0);
    end
    chk("done_edge", de, ed);
    chk("done_width", nd, ed != 0 ? 1 : 0);
    chk("pass", b0.pass, ep);
    chk("fail_cnt", b0.fail_cnt, ec);
    if (ec != 0) chk("fail_vec", b0.fail_vec, ev);
  endtask
  initial begin
    int c, v, p, ab;
    int de[4];
    logic [3:0] g;
    tbl[0] = '{4'b0111, 0, 0, 0, 0, 1, LAT0};
    tbl[1] = '{4'b0000, 0, 0, 3, 0, 0, LAT0};
    tbl[2] = '{4'b1000, 0, 0, 4, 0, 0, LAT0};
    tbl[3] = '{4'b1111, 0, 0, 1, 3, 0, LAT0};
    tbl[4] = '{4'b0011, 0, 0, 1, 2, 0, LAT0};
    tbl[5] = '{4'b0000, 5, 0, 1, 0, 0, 0};
    tbl[6] = '{4'b0111, 0, 5, 0, 0, 1, LAT0};
    tbl[7] = '{4'b1000, 1, 0, 0, 0, 0, 0};
    #12;
    chk("reset_flags", {b0.busy, b0.done, b0.pass, ga[0], gb[0]}, 0);
    chk("reset_cnt", b0.fail_cnt, 0);
    chk("reset_vec", b0.fail_vec, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++)
      run0(tbl[i].g, tbl[i].ab, tbl[i].rs, tbl[i].cnt, tbl[i].vec, tbl[i].pass, tbl[i].de);
    for (int i = 0; i < 24; i++) begin
      g = 4'($urandom);
      ab = ($urandom % 2) != 0 ? int'($urandom_range(12, 1)) : 0;
      model(g, ab, c, v, p);
      run0(g, ab, 0, c, v, p, ab != 0 ? 0 : LAT0);
    end
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_busy", b0.busy, 0);
    @(negedge clk) chk("start_abort_busy2", b0.busy, 0);
    gfun = 4'b0000;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_cnt", b0.fail_cnt, 1);
    chk("pre_rst_gate", {b0.busy, ga[0], gb[0]}, 3'b101);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", {b0.busy, b0.done, b0.pass, ga[0], gb[0], b0.fail_cnt}, 0);
    @(negedge clk) rst = 1'b0;
    gfun = 4'b0111;
    de = '{0, 0, 0, 0};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (dn[i] && de[i] == 0) de[i] = k + 1;
    end
    chk("nand_done", de[0], 13);
    chk("nand_pass", b0.pass, 1);
    chk("and_done", de[1], 13);
    chk("and_pass", b1.pass, 1);
    chk("and_cnt", b1.fail_cnt, 0);
    chk("loop3_done", de[2], 25);
    chk("loop3_cnt", b2.fail_cnt, 3);
    chk("loop3_vec", b2.fail_vec, 3);
    chk("loop3_pass", b2.pass, 0);
    chk("sat_done", de[3], 49);
    chk("sat_cnt", b3.fail_cnt, 3);
    chk("sat_vec", b3.fail_vec, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
